// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, state and ALU-select constants for the processor control unit
//
// Purpose: single home for the encodings that the controller, its PC/IR
// register pair and any datapath block must agree on.
// Contents:
//   OP_*      4-bit opcodes carried in the top nibble of the instruction
//   state_t   controller state codes, also exported on StateO
//   ALU_*     ALU operation select values driven on ALU_s
package proc_pkg;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_JMPZ  = 4'd6;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_JMPZ   = 4'd10
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/proc_pc_ir.sv
// rtl/proc_pc_ir.sv - program counter and instruction register pair
//
// Purpose: holds PC and IR for the control unit.
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset, clears PC and IR
//   clr        in   PC <= 0
//   load       in   IR <= load_data
//   load_data  in   instruction word captured by load
//   inc        in   PC <= PC + 1 (wraps modulo 2^PC_W)
//   jump       in   PC <= jump_addr
//   jump_addr  in   jump target
//   pc         out  program counter
//   ir         out  instruction register
module proc_pc_ir #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               inc,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_addr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (load) begin
        ir <= load_data;
      end
      // The controller never asserts more than one PC command per cycle;
      // the priority only makes the behaviour defined if it ever did.
      if (clr) begin
        pc <= '0;
      end else if (jump) begin
        pc <= jump_addr;
      end else if (inc) begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/proc_control_unit.sv
// rtl/proc_control_unit.sv - fetch/decode/execute controller for the programmable processor
//
// Purpose: sequences instruction fetch, decode and execution, driving the
// instruction memory, data memory, register file and ALU of the datapath.
// All control outputs are Moore outputs decoded from state and IR.
// Ports:
//   Clk, Reset_n                 clock, synchronous active-low reset
//   IM_rdata, IM_ready           instruction read data / fetch complete
//   IM_addr, IM_rd               instruction address (= PC) / fetch request
//   D_ready                      data access complete
//   D_addr, D_rd, D_wr           data address / read / write request
//   Ra_zero                      RF port A value is zero (for JMPZ)
//   RF_s, RF_W_addr, RF_W_en     RF write select (1 = memory), address, enable
//   RF_Ra_addr, RF_Rb_addr       RF read addresses
//   ALU_s                        ALU op select
//   IR_Out, PC_Out, StateO       IR, PC and state code for observation
//   Halted, Illegal              in HALT / undefined opcode seen in DECODE
module proc_control_unit
  import proc_pkg::*;
#(
  parameter  int PC_W    = 5,
  parameter  int RF_AW   = 4,
  parameter  int DM_AW   = 8,
  localparam int INSTR_W = 4 + RF_AW + DM_AW
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [INSTR_W-1:0] IM_rdata,
  input  logic               IM_ready,
  output logic [PC_W-1:0]    IM_addr,
  output logic               IM_rd,
  input  logic               D_ready,
  output logic [DM_AW-1:0]   D_addr,
  output logic               D_rd,
  output logic               D_wr,
  input  logic               Ra_zero,
  output logic               RF_s,
  output logic [RF_AW-1:0]   RF_W_addr,
  output logic               RF_W_en,
  output logic [RF_AW-1:0]   RF_Ra_addr,
  output logic [RF_AW-1:0]   RF_Rb_addr,
  output logic [2:0]         ALU_s,
  output logic [INSTR_W-1:0] IR_Out,
  output logic [PC_W-1:0]    PC_Out,
  output logic [3:0]         StateO,
  output logic               Halted,
  output logic               Illegal
);

  state_t state, state_nxt;

  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               pc_clr, ir_load, pc_inc, pc_jump;

  // Instruction fields. M overlaps A and B: it is the whole operand area
  // used as a data-memory address by LOAD.
  logic [3:0]       f_op;
  logic [RF_AW-1:0] f_a, f_b, f_d;
  logic [DM_AW-1:0] f_m, f_s;
  logic [PC_W-1:0]  f_t;

  assign f_op = ir[INSTR_W-1 -: 4];
  assign f_a  = ir[RF_AW+DM_AW-1 -: RF_AW];
  assign f_b  = ir[2*RF_AW-1 -: RF_AW];
  assign f_d  = ir[RF_AW-1:0];
  assign f_m  = ir[RF_AW+DM_AW-1 : RF_AW];
  assign f_s  = ir[DM_AW-1:0];
  assign f_t  = ir[PC_W-1:0];

  proc_pc_ir #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_pc_ir (
    .clk       (Clk),
    .reset_n   (Reset_n),
    .clr       (pc_clr),
    .load      (ir_load),
    .load_data (IM_rdata),
    .inc       (pc_inc),
    .jump      (pc_jump),
    .jump_addr (f_t),
    .pc        (pc),
    .ir        (ir)
  );

  assign IR_Out = ir;
  assign PC_Out = pc;
  assign StateO = state;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_clr     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_jump    = 1'b0;
    IM_addr    = '0;
    IM_rd      = 1'b0;
    D_addr     = '0;
    D_rd       = 1'b0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s      = ALU_PASS;
    Halted     = 1'b0;
    Illegal    = 1'b0;

    case (state)
      S_INIT: begin
        pc_clr    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        IM_rd   = 1'b1;
        IM_addr = pc;
        if (IM_ready) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (f_op)
          OP_NOOP:  state_nxt = S_NOOP;
          OP_STORE: state_nxt = S_STORE;
          OP_LOAD:  state_nxt = S_LOAD_A;
          OP_ADD:   state_nxt = S_ADD;
          OP_SUB:   state_nxt = S_SUB;
          OP_HALT:  state_nxt = S_HALT;
          OP_JMPZ:  state_nxt = S_JMPZ;
          default: begin
            // Undefined opcodes are flagged and then skipped like a NOOP.
            Illegal   = 1'b1;
            state_nxt = S_NOOP;
          end
        endcase
      end
      S_NOOP: begin
        state_nxt = S_FETCH;
      end
      S_LOAD_A: begin
        D_addr = f_m;
        D_rd   = 1'b1;
        if (D_ready) begin
          state_nxt = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        // Address stays on the bus so the read data is still valid while
        // the register file captures it.
        D_addr    = f_m;
        RF_s      = 1'b1;
        RF_W_addr = f_d;
        RF_W_en   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_STORE: begin
        RF_Ra_addr = f_a;
        D_addr     = f_s;
        D_wr       = 1'b1;
        if (D_ready) begin
          state_nxt = S_FETCH;
        end
      end
      S_ADD: begin
        RF_Ra_addr = f_a;
        RF_Rb_addr = f_b;
        ALU_s      = ALU_ADD;
        RF_W_addr  = f_d;
        RF_W_en    = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_SUB: begin
        RF_Ra_addr = f_a;
        RF_Rb_addr = f_b;
        ALU_s      = ALU_SUB;
        RF_W_addr  = f_d;
        RF_W_en    = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JMPZ: begin
        // PC already points past the JMPZ; a taken jump overrides it.
        RF_Ra_addr = f_a;
        if (Ra_zero) begin
          pc_jump = 1'b1;
        end
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

endmodule
